data_memory: RTL and testbench

Word-organised, synchronous data memory for the RISC datapath, used by load/store instructions in the memory stage. It takes a byte address (the computed immediate/effective address), stores the rt-register value on a store, and returns a registered read word on a load. Read data is driven back toward the register-file write-data path.

---
 rtl/data_memory.sv | 79 +++++++
 tb/tb_data_memory.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Word-organised synchronous data memory for the load/store stage.
// One access per cycle (store when cnt=1, load when cnt=0), byte address on imm,
// registered read data on wtd with one cycle of latency and write-first behaviour.
module data_memory #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rtd,
  output logic [DATA_W-1:0] wtd,
  input  logic [31:0]       imm,
  input  logic              cnt
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned BYTE_W = 2;
  localparam int unsigned WORD_LSB = BYTE_W;
  localparam int unsigned WORD_MSB = ADDR_W + BYTE_W - 1;
  localparam int unsigned HIGH_SHIFT = ADDR_W + BYTE_W;

  // Storage; zero at power-up so simulation matches the post-reset state.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  // Registered read data; zero before the first reset.
  logic [DATA_W-1:0] wtd_q = '0;

  logic [ADDR_W-1:0] index_c;
  logic              in_range_c;
  logic              do_store_c;
  logic [DATA_W-1:0] rd_word_c;

  // The low two byte-offset bits never select anything: accesses are word-aligned.
  logic unused_byte_offset;
  assign unused_byte_offset = &{1'b0, imm[BYTE_W-1:0]};

  // Address decode: word index and range check (any bit above the index is out of range).
  always_comb begin
    index_c    = '0;
    in_range_c = 1'b0;
    index_c    = imm[WORD_MSB:WORD_LSB];
    in_range_c = ((imm >> HIGH_SHIFT) == 32'(0));
  end

  // Access qualification and read-side mux source.
  always_comb begin
    do_store_c = 1'b0;
    rd_word_c  = '0;
    do_store_c = cnt && in_range_c;
    rd_word_c  = mem[index_c];
  end

  // Memory array update: clear everything on reset, else write on an in-range store.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (do_store_c) begin
      mem[index_c] <= rtd;
    end
  end

  // Read-data register: zero on reset or out-of-range, store data on a store, array word on a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      wtd_q <= '0;
    end else if (!in_range_c) begin
      wtd_q <= '0;
    end else if (cnt) begin
      wtd_q <= rtd;
    end else begin
      wtd_q <= rd_word_c;
    end
  end

  assign wtd = wtd_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory (DEPTH=256): reset, store/load, alignment,
// out-of-range, back-to-back and reset-over-store scenarios.
module tb_data_memory;

  logic        clk;
  logic        rst;
  logic [31:0] rtd;
  logic [31:0] wtd;
  logic [31:0] imm;
  logic        cnt;

  int errors;
  int checks;

  data_memory #(.DEPTH(256), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .rtd (rtd),
    .wtd (wtd),
    .imm (imm),
    .cnt (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one access, clock it, and leave time for wtd to settle past the edge.
  task automatic access(input logic r, input logic c, input logic [31:0] a, input logic [31:0] d);
    rst = r;
    cnt = c;
    imm = a;
    rtd = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if (wtd !== 32'h0) begin errors++; $display("FAIL powerup_wtd: got %h want %h", wtd, 32'h0); end
    checks++;
    access(1'b1, 1'b0, 32'h0, 32'h0);
    if (wtd !== 32'h0) begin errors++; $display("FAIL reset_wtd: got %h want %h", wtd, 32'h0); end
    checks++;
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    if (wtd !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_pre_store: got %h want %h", wtd, 32'hDEADBEEF); end
    checks++;
    access(1'b1, 1'b0, 32'h10, 32'h0);
    if (wtd !== 32'h0) begin errors++; $display("FAIL reset_cycle_wtd: got %h want %h", wtd, 32'h0); end
    checks++;
    access(1'b0, 1'b0, 32'h10, 32'h0);
    if (wtd !== 32'h0) begin errors++; $display("FAIL reset_clears_mem: got %h want %h", wtd, 32'h0); end
    checks++;
  endtask

  task automatic test_store_load();
    logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h3FC};
    logic [31:0] datas [3] = '{32'h12345678, 32'hCAFEF00D, 32'hFFFFFFFF};
    for (int i = 0; i < 3; i++) begin
      access(1'b0, 1'b1, addrs[i], datas[i]);
      if (wtd !== datas[i]) begin errors++; $display("FAIL store_writefirst[%0d]: got %h want %h", i, wtd, datas[i]); end
      checks++;
    end
    for (int i = 0; i < 3; i++) begin
      access(1'b0, 1'b0, addrs[i], 32'h0BAD0BAD);
      if (wtd !== datas[i]) begin errors++; $display("FAIL load[%0d]: got %h want %h", i, wtd, datas[i]); end
      checks++;
    end
  endtask

  task automatic test_alignment();
    logic [31:0] addrs [4] = '{32'h9, 32'hA, 32'hB, 32'hC};
    logic [31:0] exps  [4] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0};
    access(1'b0, 1'b1, 32'h8, 32'hA5A5A5A5);
    if (wtd !== 32'hA5A5A5A5) begin errors++; $display("FAIL align_store: got %h want %h", wtd, 32'hA5A5A5A5); end
    checks++;
    for (int i = 0; i < 4; i++) begin
      access(1'b0, 1'b0, addrs[i], 32'h0);
      if (wtd !== exps[i]) begin errors++; $display("FAIL align_load[%0d]: got %h want %h", i, wtd, exps[i]); end
      checks++;
    end
  endtask

  task automatic test_out_of_range();
    access(1'b0, 1'b1, 32'h400, 32'h11111111);
    if (wtd !== 32'h0) begin errors++; $display("FAIL oor_store_wtd: got %h want %h", wtd, 32'h0); end
    checks++;
    access(1'b0, 1'b0, 32'h0, 32'h0);
    if (wtd !== 32'h12345678) begin errors++; $display("FAIL oor_no_alias: got %h want %h", wtd, 32'h12345678); end
    checks++;
    access(1'b0, 1'b0, 32'h400, 32'h0);
    if (wtd !== 32'h0) begin errors++; $display("FAIL oor_load: got %h want %h", wtd, 32'h0); end
    checks++;
    // High bit set with an otherwise valid index: must not alias word 1.
    access(1'b0, 1'b1, 32'h80000004, 32'h22222222);
    if (wtd !== 32'h0) begin errors++; $display("FAIL oor_high_store: got %h want %h", wtd, 32'h0); end
    checks++;
    access(1'b0, 1'b0, 32'h4, 32'h0);
    if (wtd !== 32'hCAFEF00D) begin errors++; $display("FAIL oor_high_no_alias: got %h want %h", wtd, 32'hCAFEF00D); end
    checks++;
    access(1'b0, 1'b0, 32'h80000004, 32'h0);
    if (wtd !== 32'h0) begin errors++; $display("FAIL oor_high_load: got %h want %h", wtd, 32'h0); end
    checks++;
  endtask

  task automatic test_back_to_back();
    access(1'b0, 1'b1, 32'h20, 32'h1);
    access(1'b0, 1'b1, 32'h20, 32'h2);
    if (wtd !== 32'h2) begin errors++; $display("FAIL b2b_second_store: got %h want %h", wtd, 32'h2); end
    checks++;
    access(1'b0, 1'b0, 32'h20, 32'h0);
    if (wtd !== 32'h2) begin errors++; $display("FAIL b2b_last_wins: got %h want %h", wtd, 32'h2); end
    checks++;
    access(1'b0, 1'b1, 32'h20, 32'h3C3C3C3C);
    access(1'b0, 1'b0, 32'h20, 32'h0);
    if (wtd !== 32'h3C3C3C3C) begin errors++; $display("FAIL b2b_store_then_load: got %h want %h", wtd, 32'h3C3C3C3C); end
    checks++;
    // Load returns the word, then a load of another word updates the next cycle.
    access(1'b0, 1'b0, 32'h3FC, 32'h0);
    if (wtd !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_load_other: got %h want %h", wtd, 32'hFFFFFFFF); end
    checks++;
  endtask

  task automatic test_reset_with_store();
    access(1'b1, 1'b1, 32'h30, 32'h55);
    if (wtd !== 32'h0) begin errors++; $display("FAIL rst_store_wtd: got %h want %h", wtd, 32'h0); end
    checks++;
    access(1'b0, 1'b0, 32'h30, 32'h0);
    if (wtd !== 32'h0) begin errors++; $display("FAIL rst_store_dropped: got %h want %h", wtd, 32'h0); end
    checks++;
    access(1'b0, 1'b0, 32'h20, 32'h0);
    if (wtd !== 32'h0) begin errors++; $display("FAIL rst_lost_earlier: got %h want %h", wtd, 32'h0); end
    checks++;
    access(1'b0, 1'b0, 32'h3FC, 32'h0);
    if (wtd !== 32'h0) begin errors++; $display("FAIL rst_lost_top: got %h want %h", wtd, 32'h0); end
    checks++;
    access(1'b0, 1'b1, 32'h30, 32'h77);
    access(1'b0, 1'b0, 32'h30, 32'h0);
    if (wtd !== 32'h77) begin errors++; $display("FAIL post_rst_access: got %h want %h", wtd, 32'h77); end
    checks++;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    cnt = 1'b0;
    imm = 32'h0;
    rtd = 32'h0;
    #1;
    test_reset();
    test_store_load();
    test_alignment();
    test_out_of_range();
    test_back_to_back();
    test_reset_with_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
